// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin two-requester Avalon-MM arbiter in front of a single-port on-chip RAM
module onchip_mem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int BE_W       = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    output logic              mem_reset_req,
    input  logic [DATA_W-1:0] mem_readdata
);
    logic last_grant, rd_pend, rd_id;
    logic req0, req1, gnt0, gnt1, gnt_any;
    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    // last_grant=1 hands a tie to port 0, last_grant=0 hands it to port 1
    assign gnt0    = ~reset & req0 & (~req1 | last_grant);
    assign gnt1    = ~reset & req1 & (~req0 | ~last_grant);
    assign gnt_any = gnt0 | gnt1;
    assign mem_address    = gnt1 ? m1_address    : m0_address;
    assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = gnt_any;
    assign mem_write      = gnt1 ? m1_write : gnt0 & m0_write;
    assign mem_clken      = ~reset;
    assign mem_reset_req  = 1'b0;
    assign m0_waitrequest   = ~gnt0;
    assign m1_waitrequest   = ~gnt1;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend & ~rd_id;
    assign m1_readdatavalid = rd_pend & rd_id;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_id      <= 1'b0;
        end else begin
            if (gnt_any)
                last_grant <= gnt1;
            rd_pend <= gnt_any & ~mem_write;
            rd_id   <= gnt1;
        end
    end
endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-port Avalon-MM arbiter that shares the single-port 16384 x 32 on-chip memory between two requesters, the Nios instruction and data masters. It grants at most one transfer per cycle using round-robin priority. It drives the memory's slave-side signals and returns read data, with a readdatavalid strobe, to the requester that issued the read. The block sits between the system interconnect and the on-chip memory instance.

## Interface
- ADDR_W, 14: word-address width; memory depth is 2^ADDR_W.
- DATA_W, 32: data width.
- BE_W, 4: byteenable width; equals DATA_W/8.
- RD_LATENCY, 1: memory read latency in cycles; fixed at 1, since the memory output is unregistered.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  ADDR_W  requester 0 word address.
- m0_byteenable  in  BE_W  requester 0 byte lanes; used on writes only.
- m0_read  in  1  requester 0 read request.
- m0_write  in  1  requester 0 write request.
- m0_writedata  in  DATA_W  requester 0 write data.
- m0_waitrequest  out  1  low in the cycle requester 0's transfer is accepted.
- m0_readdata  out  DATA_W  read data for requester 0.
- m0_readdatavalid  out  1  m0_readdata valid this cycle.
- m1_*: same set as m0_*, for requester 1.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  BE_W  to memory byteenable.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_writedata  out  DATA_W  to memory writedata.
- mem_clken  out  1  to memory clken.
- mem_reset_req  out  1  to memory reset_req.
- mem_readdata  in  DATA_W  from memory readdata.

## Operation
- **Request.** A requester requests when read or write is high. If both are high on one port, the transfer is treated as a write and produces no readdatavalid.
- **Arbitration.** The grant decision is combinational within the cycle.
  - Only one port requesting: that port wins.
  - Both requesting: the port not granted most recently wins.
  - No request: no grant. mem_chipselect=0 and mem_write=0.
- **Priority state.** last_grant is a 1-bit register, updated only on a cycle with a grant, to the granted port id.
- **Memory side.**
  - mem_address, mem_byteenable and mem_writedata come from the granted port's fields. When there is no grant they come from port 0 (don't-care).
  - mem_chipselect = grant_any.
  - mem_write = grant_any & granted port's write.
  - mem_clken = 1 and mem_reset_req = 0 at all times outside reset.
- **Waitrequest.** mN_waitrequest = ~(grant to N). Waitrequest is high when a port is idle.
- **Read return.** The block keeps registers rd_pend (1 bit) and rd_id (1 bit).
  - On a granted read: rd_pend<=1 and rd_id<=granted port. Otherwise rd_pend<=0.
  - mN_readdatavalid = rd_pend & (rd_id==N).
  - m0_readdata and m1_readdata = mem_readdata. Both ports see the same bus and are qualified by readdatavalid.
- **Reset.**
  - While reset is high, all grants are suppressed: both waitrequest=1, mem_chipselect=0, mem_write=0, mem_clken=0.
  - Asynchronous entry to reset clears rd_pend=0, rd_id=0, and last_grant=1, so port 0 wins the first contention.
  - readdatavalid goes 0 immediately on reset assertion. A read in flight when reset asserts is dropped.

## Timing
- The grant is visible as waitrequest low in the same cycle the request is presented (cycle N). Zero-wait accept when uncontended.
- A write commits at the rising edge ending cycle N.
- For a read granted in cycle N, readdatavalid is high and readdata valid in cycle N+1, for exactly 1 cycle.
- Back-to-back grants are supported at one transfer per cycle, with a pipelined read return. There is no cap on outstanding reads beyond the 1-deep pipe.
- **Contention.**
  - Both ports continuously requesting alternate grants every cycle.
  - A port that loses holds its request, per Avalon rules, until its waitrequest goes low.
  - Worst-case wait for a losing port is 1 cycle.
- Read-during-write to the same address within one cycle cannot occur, because the memory is single-ported and only one transfer is granted per cycle.
- Requester inputs are sampled only in the granted cycle. Changes while waitrequest is high do not corrupt state.

## Test plan
- **Reset.** Assert reset mid-read, with m0 read of addr 5 granted the previous cycle.
  - Required response: readdatavalid=0 at once, both waitrequest=1, mem_chipselect=0.
  - After release: last_grant=1.
- **Single-port write/read.**
  - Stimulus: m0 writes 0xDEADBEEF with be=0xF to addr 0x0010, then reads it.
  - Required response: waitrequest low in both request cycles. m0_readdatavalid high 1 cycle after the read grant, with data 0xDEADBEEF. m1_readdatavalid stays 0.
- **Byte enables.**
  - Stimulus: write 0x11223344 to addr 0x3FFF, then write 0xAABBCCDD with be=0x5, then read.
  - Required response: read returns 0x11BB33DD.
- **Contention.**
  - Stimulus: both ports issue continuous reads from the first cycle after reset, m0 from addr 1 and m1 from addr 2, preloaded with 0x1 and 0x2.
  - Required response: grants alternate m0,m1,m0,… and each readdatavalid strobe arrives with its own value one cycle after its grant.
- **Read+write conflict.**
  - Stimulus: m1 asserts read and write together to addr 7 with data 0x55.
  - Required response: memory written with 0x55, and no m1_readdatavalid.
- **Mixed pipeline.**
  - Stimulus: m0 write of 0x77 to addr 9 contends with an m1 read of addr 9, with last_grant=1.
  - Required response: m0 is granted first and m1 next cycle. m1 reads 0x77.
